// File: rtl/lsu_dbus_ctrl.sv
// Load-store unit: aligns store lanes, issues one bus request per access,
// waits for ack with a timeout, and returns extended load data.
module lsu_dbus_ctrl #(
  parameter logic [31:0] DMEM_BASE   = 32'h0000_0000,
  parameter logic [31:0] DMEM_SIZE   = 32'h0000_4000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_req_i,
  input  logic        exe_we_i,
  input  logic [1:0]  exe_size_i,
  input  logic        exe_unsigned_i,
  input  logic [31:0] exe_addr_i,
  input  logic [31:0] exe_wdata_i,
  output logic        lsu_stall_o,
  output logic        lsu_done_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_misalign_o,
  output logic        lsu_buserr_o,
  output logic [31:0] lsu_badaddr_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_sel_byte_o,
  output logic        dmem_sel_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i
);

  // Counter spans the WAIT cycles 0..ACK_TIMEOUT-1
  localparam int CW = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] tmo_cnt;
  logic          we_q, uns_q, err_q, misalign_q, dmem_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q, wdata_q, rdata_q, badaddr_q;
  logic [3:0]    sel_q;

  logic          misaligned, accept, tmo_hit, in_win;
  logic [3:0]    sel_nxt;
  logic [31:0]   wdata_nxt, rshift, rext;
  logic [32:0]   win_end;

  // Request classification and timeout detection
  always_comb begin
    misaligned = ((exe_size_i == 2'b01) && exe_addr_i[0]) ||
                 (exe_size_i[1] && (exe_addr_i[1:0] != 2'b00));
    accept     = (state == IDLE) && exe_req_i && !misaligned;
    tmo_hit    = (tmo_cnt == CW'(ACK_TIMEOUT - 1));
    win_end    = {1'b0, DMEM_BASE} + {1'b0, DMEM_SIZE};
    in_win     = (exe_addr_i >= DMEM_BASE) && ({1'b0, exe_addr_i} < win_end);
  end

  // Store lane placement: enables shifted by offset, data replicated across lanes
  always_comb begin
    sel_nxt   = 4'b1111;
    wdata_nxt = exe_wdata_i;
    case (exe_size_i)
      2'b00: begin
        sel_nxt   = 4'b0001 << exe_addr_i[1:0];
        wdata_nxt = {4{exe_wdata_i[7:0]}};
      end
      2'b01: begin
        sel_nxt   = 4'b0011 << exe_addr_i[1:0];
        wdata_nxt = {2{exe_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load return: shift addressed bytes down, then sign/zero extend
  always_comb begin
    rshift = dbus_rdata_i >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   rext = uns_q ? {24'h0, rshift[7:0]}  : {{24{rshift[7]}}, rshift[7:0]};
      2'b01:   rext = uns_q ? {16'h0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      default: rext = rshift;
    endcase
  end

  // Next-state logic and state-derived outputs
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (dbus_ack_i || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    lsu_stall_o     = accept || (state == ISSUE) || (state == WAIT);
    lsu_done_o      = (state == RESP);
    lsu_buserr_o    = (state == RESP) && err_q;
    dbus_req_o      = (state == ISSUE);
    lsu_misalign_o  = misalign_q;
    lsu_rdata_o     = rdata_q;
    lsu_badaddr_o   = badaddr_q;
    dbus_we_o       = we_q;
    dbus_addr_o     = {addr_q[31:2], 2'b00};
    dbus_wdata_o    = wdata_q;
    dbus_sel_byte_o = sel_q;
    dmem_sel_o      = dmem_q;
  end

  // State register, request latch, timeout counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      dmem_q     <= 1'b0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
      rdata_q    <= '0;
      badaddr_q  <= '0;
    end else begin
      state      <= state_nxt;
      misalign_q <= (state == IDLE) && exe_req_i && misaligned;
      if ((state == IDLE) && exe_req_i && misaligned)
        badaddr_q <= exe_addr_i;
      if (accept) begin
        we_q    <= exe_we_i;
        uns_q   <= exe_unsigned_i;
        size_q  <= exe_size_i;
        addr_q  <= exe_addr_i;
        wdata_q <= wdata_nxt;
        sel_q   <= sel_nxt;
        dmem_q  <= in_win;
        tmo_cnt <= '0;
      end
      if (state == WAIT) begin
        if (dbus_ack_i) begin
          rdata_q <= we_q ? 32'h0 : rext;
          err_q   <= 1'b0;
          tmo_cnt <= '0;
        end else if (tmo_hit) begin
          rdata_q   <= 32'h0;
          err_q     <= 1'b1;
          badaddr_q <= addr_q;
          tmo_cnt   <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_dbus_ctrl.sv
// Bench for lsu_dbus_ctrl: directed vector table, reset corner sequences,
// and randomized accesses checked against an arithmetic reference model.
module tb_lsu_dbus_ctrl;
  localparam int          T    = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SIZE = 32'h0000_4000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        exe_req = 0, exe_we = 0, exe_uns = 0;
  logic [1:0]  exe_size = 0;
  logic [31:0] exe_addr = 0, exe_wdata = 0, dbus_rdata = 0;
  logic        dbus_ack = 0;
  logic        lsu_stall, lsu_done, lsu_misalign, lsu_buserr;
  logic        dbus_req, dbus_we, dmem_sel;
  logic [31:0] lsu_rdata, lsu_badaddr, dbus_addr, dbus_wdata;
  logic [3:0]  dbus_sel;

  int checks = 0, errors = 0;

  lsu_dbus_ctrl #(.DMEM_BASE(BASE), .DMEM_SIZE(SIZE), .ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .exe_req_i(exe_req), .exe_we_i(exe_we), .exe_size_i(exe_size),
    .exe_unsigned_i(exe_uns), .exe_addr_i(exe_addr), .exe_wdata_i(exe_wdata),
    .lsu_stall_o(lsu_stall), .lsu_done_o(lsu_done), .lsu_rdata_o(lsu_rdata),
    .lsu_misalign_o(lsu_misalign), .lsu_buserr_o(lsu_buserr), .lsu_badaddr_o(lsu_badaddr),
    .dbus_req_o(dbus_req), .dbus_we_o(dbus_we), .dbus_addr_o(dbus_addr),
    .dbus_wdata_o(dbus_wdata), .dbus_sel_byte_o(dbus_sel), .dmem_sel_o(dmem_sel),
    .dbus_rdata_i(dbus_rdata), .dbus_ack_i(dbus_ack));

  always #5 clk = ~clk;

  typedef struct {
    logic we; logic [1:0] size; logic uns;
    logic [31:0] addr, wd, mem; int ackd;
    logic [31:0] e_rdata, e_wdata; logic [3:0] e_sel;
    logic e_mis, e_err, e_dmem; int e_done;
  } vec_t;

  typedef struct {
    int done_cyc, stall_cnt, mis_cnt, mis_cyc, nreq;
    logic [31:0] rdata, badaddr, wdata, addr; logic [3:0] sel;
    logic err, we, dmem;
  } res_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
      input logic [31:0] addr, wd, mem, input int ackd, input logic [31:0] e_rdata,
      input logic [3:0] e_sel, input logic [31:0] e_wdata, input logic e_mis, e_err, e_dmem,
      input int e_done);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wd = wd; v.mem = mem; v.ackd = ackd;
    v.e_rdata = e_rdata; v.e_sel = e_sel; v.e_wdata = e_wdata;
    v.e_mis = e_mis; v.e_err = e_err; v.e_dmem = e_dmem; v.e_done = e_done;
    return v;
  endfunction

  // Reference model: byte counts, modular arithmetic and lane loops
  function automatic vec_t model(input vec_t v);
    vec_t   m = v;
    int     nb, o, lo;
    longint val, half;
    nb = (v.size == 0) ? 1 : (v.size == 1) ? 2 : 4;
    o  = int'(v.addr % 4);
    m.e_mis  = (v.addr % nb) != 0;
    m.e_dmem = (longint'(v.addr) >= longint'(BASE)) &&
               (longint'(v.addr) < longint'(BASE) + longint'(SIZE));
    lo = (nb == 4) ? 0 : o;
    m.e_sel = 0; m.e_wdata = 0;
    for (int i = 0; i < 4; i++) begin
      if (i >= lo && i < lo + nb) m.e_sel[i] = 1'b1;
      m.e_wdata[8*i +: 8] = 8'((v.wd >> (8 * (i % nb))) & 255);
    end
    m.e_err = !m.e_mis && !(v.ackd >= 1 && v.ackd <= T);
    m.e_done = m.e_mis ? 0 : (m.e_err ? T + 2 : v.ackd + 2);
    val  = (longint'(v.mem) >> (8 * o)) % (longint'(1) << (8 * nb));
    half = longint'(1) << (8 * nb - 1);
    if (!v.uns && nb < 4 && val >= half) val = val + (longint'(1) << 32) - (half * 2);
    m.e_rdata = (v.we || m.e_err) ? 32'h0 : 32'(val);
    return m;
  endfunction

  // Drive one access and act as the bus slave; bounded to 30 cycles
  task automatic run(input vec_t v, output res_t r);
    int cyc, req_cyc;
    r = '{default: 0};
    req_cyc = -100;
    @(posedge clk); #1;
    exe_req = 1; exe_we = v.we; exe_size = v.size; exe_uns = v.uns;
    exe_addr = v.addr; exe_wdata = v.wd; dbus_ack = 0;
    cyc = 0;
    while (cyc < 30) begin
      @(negedge clk);
      if (lsu_stall) r.stall_cnt++;
      if (lsu_misalign) begin r.mis_cnt++; r.mis_cyc = cyc; r.badaddr = lsu_badaddr; end
      if (dbus_req) begin
        r.nreq++; req_cyc = cyc;
        r.sel = dbus_sel; r.wdata = dbus_wdata; r.we = dbus_we; r.addr = dbus_addr; r.dmem = dmem_sel;
        if (v.ackd == 0) begin dbus_ack = 1; dbus_rdata = v.mem; end
      end
      if (lsu_done) begin
        r.done_cyc = cyc; r.rdata = lsu_rdata; r.err = lsu_buserr;
        if (lsu_buserr) r.badaddr = lsu_badaddr;
        break;
      end
      if (v.e_mis && cyc >= 4) break;
      @(posedge clk); #1;
      cyc++;
      if (v.e_mis) exe_req = 0;
      dbus_ack = (v.ackd > 0) && (cyc == req_cyc + v.ackd);
      dbus_rdata = dbus_ack ? v.mem : $urandom;
    end
    @(posedge clk); #1;
    exe_req = 0; dbus_ack = 0;
  endtask

  task automatic check_vec(input vec_t v, input res_t r);
    chk("done_cycle", r.done_cyc, v.e_done);
    chk("stall_cycles", r.stall_cnt, v.e_done);
    chk("misalign_pulses", r.mis_cnt, 32'(v.e_mis));
    chk("bus_requests", r.nreq, v.e_mis ? 0 : 1);
    if (v.e_mis) begin
      chk("misalign_cycle", r.mis_cyc, 1);
      chk("badaddr_misalign", r.badaddr, v.addr);
    end else begin
      chk("rdata", r.rdata, v.e_rdata);
      chk("buserr", 32'(r.err), 32'(v.e_err));
      chk("sel_byte", 32'(r.sel), 32'(v.e_sel));
      chk("bus_we", 32'(r.we), 32'(v.we));
      chk("bus_addr", r.addr, {v.addr[31:2], 2'b00});
      chk("dmem_sel", 32'(r.dmem), 32'(v.e_dmem));
      if (v.we) chk("bus_wdata", r.wdata, v.e_wdata);
      if (v.e_err) chk("badaddr_buserr", r.badaddr, v.addr);
    end
  endtask

  vec_t tbl[15];
  vec_t v;
  res_t r;
  int   nd;

  initial begin
    //            we sz u addr          wd            mem           ackd rdata         sel      wdata         mis err dm done
    tbl[0]  = mk(0, 2, 0, 32'h100,      32'h0,        32'hDEADBEEF, 1,  32'hDEADBEEF, 4'b1111, 32'h0,        0, 0, 1, 3);
    tbl[1]  = mk(0, 0, 0, 32'h103,      32'h0,        32'h80FF0000, 1,  32'hFFFFFF80, 4'b1000, 32'h0,        0, 0, 1, 3);
    tbl[2]  = mk(0, 0, 1, 32'h103,      32'h0,        32'h80FF0000, 1,  32'h00000080, 4'b1000, 32'h0,        0, 0, 1, 3);
    tbl[3]  = mk(1, 1, 0, 32'h102,      32'h1234ABCD, 32'h0,        1,  32'h0,        4'b1100, 32'hABCDABCD, 0, 0, 1, 3);
    tbl[4]  = mk(0, 2, 0, 32'h101,      32'h0,        32'h0,        1,  32'h0,        4'b0000, 32'h0,        1, 0, 0, 0);
    tbl[5]  = mk(0, 2, 0, 32'h80000000, 32'h0,        32'h11111111, 99, 32'h0,        4'b1111, 32'h0,        0, 1, 0, 18);
    tbl[6]  = mk(0, 1, 0, 32'h102,      32'h0,        32'h80011234, 2,  32'hFFFF8001, 4'b1100, 32'h0,        0, 0, 1, 4);
    tbl[7]  = mk(0, 1, 1, 32'h102,      32'h0,        32'h80011234, 3,  32'h00008001, 4'b1100, 32'h0,        0, 0, 1, 5);
    tbl[8]  = mk(1, 0, 0, 32'h101,      32'h000055AA, 32'h0,        1,  32'h0,        4'b0010, 32'hAAAAAAAA, 0, 0, 1, 3);
    tbl[9]  = mk(0, 3, 0, 32'h3FFC,     32'h0,        32'hCAFEF00D, 16, 32'hCAFEF00D, 4'b1111, 32'h0,        0, 0, 1, 18);
    tbl[10] = mk(0, 2, 0, 32'h4000,     32'h0,        32'h12345678, 0,  32'h0,        4'b1111, 32'h0,        0, 1, 0, 18);
    tbl[11] = mk(0, 1, 0, 32'h103,      32'h0,        32'h0,        1,  32'h0,        4'b0000, 32'h0,        1, 0, 0, 0);
    tbl[12] = mk(1, 2, 0, 32'h102,      32'h9,        32'h0,        1,  32'h0,        4'b0000, 32'h0,        1, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 32'h3,        32'hFFFFFF7E, 32'h0,        2,  32'h0,        4'b1000, 32'h7E7E7E7E, 0, 0, 1, 4);
    tbl[14] = mk(0, 1, 0, 32'h0,        32'h0,        32'h12347FFF, 1,  32'h00007FFF, 4'b0011, 32'h0,        0, 0, 1, 3);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(lsu_stall), 0);
    chk("rst_done", 32'(lsu_done), 0);
    chk("rst_req", 32'(dbus_req), 0);
    chk("rst_rdata", lsu_rdata, 0);
    chk("rst_badaddr", lsu_badaddr, 0);
    chk("rst_sel", 32'(dbus_sel), 0);
    chk("rst_wdata", dbus_wdata, 0);
    chk("rst_flags", {27'h0, lsu_misalign, lsu_buserr, dbus_we, dmem_sel, 1'b0}, 0);
    @(posedge clk); #1 rst = 0;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      run(tbl[i], r);
      check_vec(tbl[i], r);
    end

    // Reset during WAIT, then a late ack must be ignored
    @(posedge clk); #1;
    exe_req = 1; exe_we = 0; exe_size = 2; exe_uns = 0; exe_addr = 32'h200;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0; exe_req = 0;
    @(negedge clk);
    chk("midrst_stall", 32'(lsu_stall), 0);
    chk("midrst_done", 32'(lsu_done), 0);
    chk("midrst_req", 32'(dbus_req), 0);
    chk("midrst_rdata", lsu_rdata, 0);
    chk("midrst_addr", dbus_addr, 0);
    @(posedge clk); #1;
    dbus_ack = 1; dbus_rdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    dbus_ack = 0;
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (lsu_done || lsu_stall || dbus_req) nd++;
    end
    chk("late_ack_ignored", nd, 0);
    chk("late_ack_rdata", lsu_rdata, 0);
    // Counter must restart cleanly: full timeout on the next access
    run(tbl[5], r);
    check_vec(tbl[5], r);

    // Randomized accesses against the reference model
    for (int n = 0; n < 150; n++) begin
      v.we = 1'($urandom); v.size = 2'($urandom); v.uns = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       v.addr = $urandom & 32'h0000_3FFF;
        1:       v.addr = 32'h0000_3FF8 + ($urandom & 32'hF);
        2:       v.addr = 32'h8000_0000 | ($urandom & 32'hFF);
        default: v.addr = $urandom;
      endcase
      v.wd = $urandom; v.mem = $urandom;
      case ($urandom_range(0, 9))
        0:       v.ackd = 0;
        1:       v.ackd = T + 3;
        2:       v.ackd = T;
        default: v.ackd = $urandom_range(1, 5);
      endcase
      v = model(v);
      run(v, r);
      check_vec(v, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
